// File: rtl/transmissor_paridade.sv
// Serial transmitter for the 5-bit parity link: latches B1..B5 on inicio and
// sends start, B1..B5, parity and stop, each held for CICLOS_POR_BIT clocks.
module transmissor_paridade #(
    parameter int CICLOS_POR_BIT = 4,
    parameter bit PARIDADE_IMPAR = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic B4,
    input  logic B5,
    input  logic inicio,
    output logic saida_serial,
    output logic bitparidade,
    output logic ocupado,
    output logic pronto
);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARIDADE,
        PARADA
    } estado_t;

    localparam logic [7:0] ULTIMO_CICLO = 8'(CICLOS_POR_BIT - 1);

    estado_t    estado_q;
    logic [7:0] ciclo_q;
    logic [2:0] indice_q;
    logic [4:0] dados_q;
    logic       saida_q;
    logic       paridade_q;
    logic       ocupado_q;
    logic       pronto_q;

    logic       paridade_d;
    logic       fim_bit;

    always_comb begin
        paridade_d = B1 ^ B2 ^ B3 ^ B4 ^ B5 ^ PARIDADE_IMPAR;
        fim_bit    = (ciclo_q == ULTIMO_CICLO);
    end

    // saida_q is loaded one edge ahead with the next bit, so the line changes
    // exactly when the state does and the output stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            ciclo_q    <= 8'd0;
            indice_q   <= 3'd0;
            dados_q    <= 5'd0;
            saida_q    <= 1'b1;
            paridade_q <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            if (estado_q != OCIOSO) begin
                ciclo_q <= fim_bit ? 8'd0 : ciclo_q + 8'd1;
            end
            case (estado_q)
                OCIOSO: begin
                    if (inicio) begin
                        dados_q    <= {B5, B4, B3, B2, B1};
                        paridade_q <= paridade_d;
                        ocupado_q  <= 1'b1;
                        saida_q    <= 1'b0;
                        ciclo_q    <= 8'd0;
                        indice_q   <= 3'd0;
                        estado_q   <= INICIO;
                    end
                end
                INICIO: begin
                    if (fim_bit) begin
                        saida_q  <= dados_q[0];
                        estado_q <= DADOS;
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        if (indice_q == 3'd4) begin
                            saida_q  <= paridade_q;
                            indice_q <= 3'd0;
                            estado_q <= PARIDADE;
                        end else begin
                            indice_q <= indice_q + 3'd1;
                            dados_q  <= {1'b0, dados_q[4:1]};
                            saida_q  <= dados_q[1];
                        end
                    end
                end
                PARIDADE: begin
                    if (fim_bit) begin
                        saida_q  <= 1'b1;
                        estado_q <= PARADA;
                    end
                end
                PARADA: begin
                    if (fim_bit) begin
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= OCIOSO;
                    end
                end
                default: begin
                    saida_q   <= 1'b1;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign saida_serial = saida_q;
    assign bitparidade  = paridade_q;
    assign ocupado      = ocupado_q;
    assign pronto       = pronto_q;

endmodule

// File: tb/tb_transmissor_paridade.sv
// Directed bench for transmissor_paridade: three instances (even/4, odd/4,
// even/1) driven from a vector table plus reset and back-to-back sequences.
module tb_transmissor_paridade;

    logic clk;
    logic reset;
    logic B1, B2, B3, B4, B5;
    logic ini   [3];
    logic saida [3];
    logic par   [3];
    logic ocup  [3];
    logic pronto[3];

    int n_checks;
    int n_fail;

    typedef struct {
        int         inst;
        logic [4:0] word;
        logic       parity;
        logic [7:0] frame;
        bit         perturb;
    } vec_t;

    vec_t vecs[9];

    transmissor_paridade #(.CICLOS_POR_BIT(4), .PARIDADE_IMPAR(1'b0)) u_par (
        .clk(clk), .reset(reset), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5),
        .inicio(ini[0]), .saida_serial(saida[0]), .bitparidade(par[0]),
        .ocupado(ocup[0]), .pronto(pronto[0])
    );

    transmissor_paridade #(.CICLOS_POR_BIT(4), .PARIDADE_IMPAR(1'b1)) u_impar (
        .clk(clk), .reset(reset), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5),
        .inicio(ini[1]), .saida_serial(saida[1]), .bitparidade(par[1]),
        .ocupado(ocup[1]), .pronto(pronto[1])
    );

    transmissor_paridade #(.CICLOS_POR_BIT(1), .PARIDADE_IMPAR(1'b0)) u_rapido (
        .clk(clk), .reset(reset), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5),
        .inicio(ini[2]), .saida_serial(saida[2]), .bitparidade(par[2]),
        .ocupado(ocup[2]), .pronto(pronto[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nome, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", nome, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input int inst, input logic exp_par);
        chk("idle_saida", saida[inst], 1'b1);
        chk("idle_ocupado", ocup[inst], 1'b0);
        chk("idle_pronto", pronto[inst], 1'b0);
        chk("idle_bitparidade", par[inst], exp_par);
    endtask

    // One full frame: latch, 8*cpb busy cycles, pronto cycle, idle after.
    task automatic run_frame(input int inst, input logic [4:0] word, input logic parity,
                             input logic [7:0] frame, input bit perturb);
        int cpb;
        int bi;
        logic [5:0] rx;
        cpb = (inst == 2) ? 1 : 4;
        rx  = 6'd0;
        @(negedge clk);
        {B1, B2, B3, B4, B5} = word;
        ini[inst] = 1'b1;
        @(negedge clk);
        ini[inst] = 1'b0;
        for (int k = 0; k < 8 * cpb; k++) begin
            if (perturb && k == 9) begin
                ini[inst] = 1'b1;
                {B1, B2, B3, B4, B5} = ~word;
            end
            if (perturb && k == 20) ini[inst] = 1'b0;
            bi = k / cpb;
            chk("frame_bit", saida[inst], frame[7 - bi]);
            chk("frame_ocupado", ocup[inst], 1'b1);
            chk("frame_pronto", pronto[inst], 1'b0);
            chk("frame_bitparidade", par[inst], parity);
            if ((k % cpb) == (cpb / 2) && bi >= 1 && bi <= 6) rx[bi - 1] = saida[inst];
            @(negedge clk);
        end
        chk("end_pronto", pronto[inst], 1'b1);
        chk("end_ocupado", ocup[inst], 1'b0);
        chk("end_saida", saida[inst], 1'b1);
        chk("end_bitparidade", par[inst], parity);
        // Far-end checker: parity matches when XOR of all six equals the odd flag.
        chk("receiver_match", ((^rx) == (inst == 1)), 1'b1);
        for (int j = 0; j < (perturb ? 4 : 1); j++) begin
            @(negedge clk);
            chk_idle(inst, parity);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        {B1, B2, B3, B4, B5} = 5'b00000;
        for (int i = 0; i < 3; i++) ini[i] = 1'b0;

        vecs[0] = '{0, 5'b10110, 1'b1, 8'b01011011, 1'b0};
        vecs[1] = '{0, 5'b00000, 1'b0, 8'b00000001, 1'b0};
        vecs[2] = '{0, 5'b11000, 1'b0, 8'b01100001, 1'b0};
        vecs[3] = '{0, 5'b01010, 1'b0, 8'b00101001, 1'b0};
        vecs[4] = '{0, 5'b11111, 1'b1, 8'b01111111, 1'b0};
        vecs[5] = '{1, 5'b10000, 1'b0, 8'b01000001, 1'b0};
        vecs[6] = '{1, 5'b00000, 1'b1, 8'b00000011, 1'b0};
        vecs[7] = '{0, 5'b10110, 1'b1, 8'b01011011, 1'b1};
        vecs[8] = '{2, 5'b11000, 1'b0, 8'b01100001, 1'b0};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, 1'b0);

        for (int v = 0; v < 9; v++) begin
            run_frame(vecs[v].inst, vecs[v].word, vecs[v].parity, vecs[v].frame, vecs[v].perturb);
        end

        // Reset during the third data bit abandons the frame without pronto.
        @(negedge clk);
        {B1, B2, B3, B4, B5} = 5'b10110;
        ini[0] = 1'b1;
        @(negedge clk);
        ini[0] = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_reset_b3", saida[0], 1'b1);
        chk("pre_reset_ocupado", ocup[0], 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_idle(0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk_idle(0, 1'b0);
        end
        run_frame(0, 5'b10110, 1'b1, 8'b01011011, 1'b0);

        // CICLOS_POR_BIT=1 with inicio held: 8 busy cycles + 1 idle/pronto cycle.
        @(negedge clk);
        {B1, B2, B3, B4, B5} = 5'b10110;
        ini[2] = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 8; k++) begin
                chk("b2b_bit", saida[2], vecs[0].frame[7 - k]);
                chk("b2b_ocupado", ocup[2], 1'b1);
                chk("b2b_pronto", pronto[2], 1'b0);
                @(negedge clk);
            end
            chk("b2b_gap_pronto", pronto[2], 1'b1);
            chk("b2b_gap_ocupado", ocup[2], 1'b0);
            chk("b2b_gap_saida", saida[2], 1'b1);
            if (f == 2) ini[2] = 1'b0;
            @(negedge clk);
        end
        chk_idle(2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
